// File: rtl/ebus_ctl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ebus_ctl_pkg
// Brief    : Shared KL10 EBUS types plus the EBUS sequencer state encoding
//            and function-class helpers.
// Revision : 1.0 - initial release
// ============================================================================
package ebus_ctl_pkg;

    // EBUS function codes; 3'b110 and 3'b111 are undefined on the bus.
    typedef enum logic [2:0] {
        ebusfCONO     = 3'b000,
        ebusfCONI     = 3'b001,
        ebusfDATAO    = 3'b010,
        ebusfDATAI    = 3'b011,
        ebusfPIserved = 3'b100,
        ebusfPIaddrIn = 3'b101
    } tEBUSfunction;

    // One EBUS driver slot: the bus mux ORs/selects the slots that drive.
    typedef struct packed {
        logic        driving;
        logic [35:0] data;
    } tEBUSdriver;

    // Sequencer states.
    typedef enum logic [2:0] {
        ECS_IDLE     = 3'd0,
        ECS_DEMAND   = 3'd1,
        ECS_WAITXFER = 3'd2,
        ECS_RELEASE  = 3'd3,
        ECS_RESET    = 3'd4
    } tEbusCtlState;

    // Function codes that no EBUS device decodes.
    localparam logic [2:0] c_EBUSF_UNDEF6 = 3'b110;
    localparam logic [2:0] c_EBUSF_UNDEF7 = 3'b111;

    // Write-class functions put EBOX data on the bus.
    function automatic logic isWriteFunc(input tEBUSfunction f);
        case (f)
            ebusfCONO, ebusfDATAO, ebusfPIserved: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

    function automatic logic isUndefFunc(input tEBUSfunction f);
        return (3'(f) == c_EBUSF_UNDEF6) || (3'(f) == c_EBUSF_UNDEF7);
    endfunction

endpackage : ebus_ctl_pkg
`default_nettype wire

// File: rtl/ebus_ctl_if.sv
`default_nettype none
// ============================================================================
// Module   : ebus_ctl_if
// Brief    : EBOX request side and EBUS side of the EBUS sequencer.
//            master = the sequencer (sole EBUS master), slave = EBOX/bus side.
// Revision : 1.0 - initial release
// ============================================================================
interface ebus_ctl_if;
    import ebus_ctl_pkg::*;

    // EBOX request side
    logic         req;
    tEBUSfunction reqFunc;
    logic [6:0]   reqCs;
    logic [35:0]  reqData;
    logic         resetReq;
    logic         busy;
    logic         done;
    logic         timeout;
    logic         badFunc;
    logic [35:0]  rdata;

    // EBUS side
    logic [6:0]   ebusCs;
    tEBUSfunction ebusFunc;
    logic         ebusDemand;
    logic         ebusReset;
    tEBUSdriver   ebusDrv;
    logic [35:0]  ebusData;
    logic         ebusAck;
    logic         ebusXfer;

    modport master (
        input  req, reqFunc, reqCs, reqData, resetReq,
        output busy, done, timeout, badFunc, rdata,
        output ebusCs, ebusFunc, ebusDemand, ebusReset, ebusDrv,
        input  ebusData, ebusAck, ebusXfer
    );

    modport slave (
        output req, reqFunc, reqCs, reqData, resetReq,
        input  busy, done, timeout, badFunc, rdata,
        input  ebusCs, ebusFunc, ebusDemand, ebusReset, ebusDrv,
        output ebusData, ebusAck, ebusXfer
    );

endinterface : ebus_ctl_if
`default_nettype wire

// File: rtl/ebus_timer.sv
`default_nettype none
// ============================================================================
// Module   : ebus_timer
// Brief    : Phase timer: clears on load, counts up each cycle, saturates at
//            all-ones and flags when the count equals the supplied limit.
// Revision : 1.0 - initial release
// ============================================================================
module ebus_timer #(
    parameter int WIDTH = 6
) (
    input  wire              clk,
    input  wire              resetN,
    input  wire              i_load,
    input  wire [WIDTH-1:0]  i_limit,
    output logic             o_hit
);

    localparam logic [WIDTH-1:0] c_SAT = '1;

    logic [WIDTH-1:0] r_count;

    // Count cycles since the last load; stop at the top instead of wrapping.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (r_count != c_SAT) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_hit = (r_count == i_limit);

endmodule : ebus_timer
`default_nettype wire

// File: rtl/ebus_ctl.sv
`default_nettype none
// ============================================================================
// Module   : ebus_ctl
// Brief    : EBOX-side EBUS transaction sequencer. Runs demand/ack/xfer for
//            one request at a time, returns read data, flags timeouts and
//            generates the EBUS reset pulse.
// Revision : 1.0 - initial release
// ============================================================================
module ebus_ctl
    import ebus_ctl_pkg::*;
#(
    parameter int ACK_TIMEOUT  = 32,
    parameter int XFER_TIMEOUT = 64,
    parameter int RESET_CYCLES = 8
) (
    input  wire        clk,
    input  wire        resetN,
    ebus_ctl_if.master bus
);

    // The one timer also paces the reset pulse, so it is sized for all three.
    localparam int c_MAX_AX  = (ACK_TIMEOUT > XFER_TIMEOUT) ? ACK_TIMEOUT : XFER_TIMEOUT;
    localparam int c_MAX_ALL = (c_MAX_AX > RESET_CYCLES) ? c_MAX_AX : RESET_CYCLES;
    localparam int c_CNT_W   = (c_MAX_ALL > 2) ? $clog2(c_MAX_ALL) : 1;

    localparam logic [c_CNT_W-1:0] c_ACK_LAST  = c_CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_XFER_LAST = c_CNT_W'(XFER_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_RST_LAST  = c_CNT_W'(RESET_CYCLES - 1);

    tEbusCtlState       r_state;
    tEbusCtlState       w_next;

    tEBUSfunction       r_func;
    tEBUSfunction       w_func_nxt;
    logic [6:0]         r_cs;
    logic [6:0]         w_cs_nxt;
    logic [35:0]        r_wdata;
    logic [35:0]        w_wdata_nxt;
    logic               r_rst_pend;

    logic [c_CNT_W-1:0] w_limit;
    logic               w_load;
    logic               w_hit;

    logic               w_fin_timeout;
    logic               w_fin_bad;
    logic               w_capture;
    logic               w_on_bus;
    logic               w_drive;

    logic               r_busy;
    logic               r_done;
    logic               r_timeout;
    logic               r_bad_func;
    logic [35:0]        r_rdata;
    logic [6:0]         r_ebus_cs;
    tEBUSfunction       r_ebus_func;
    logic               r_demand;
    logic               r_ebus_reset;
    tEBUSdriver         r_drv;

    // Restart the timer on every state change so each phase counts from 0.
    assign w_load = (w_next != r_state);

    ebus_timer #(
        .WIDTH (c_CNT_W)
    ) u_timer (
        .clk     (clk),
        .resetN  (resetN),
        .i_load  (w_load),
        .i_limit (w_limit),
        .o_hit   (w_hit)
    );

    // State register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= ECS_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, request latching and completion qualifiers.
    always_comb begin
        w_next        = r_state;
        w_func_nxt    = r_func;
        w_cs_nxt      = r_cs;
        w_wdata_nxt   = r_wdata;
        w_limit       = c_ACK_LAST;
        w_fin_timeout = 1'b0;
        w_fin_bad     = 1'b0;
        w_capture     = 1'b0;
        case (r_state)
            ECS_IDLE: begin
                if (bus.resetReq || r_rst_pend) begin
                    w_next = ECS_RESET;
                end else if (bus.req && !bus.ebusXfer) begin
                    // A still-asserted xfer belongs to a slow device; hold off.
                    w_func_nxt  = bus.reqFunc;
                    w_cs_nxt    = bus.reqCs;
                    w_wdata_nxt = bus.reqData;
                    if (isUndefFunc(bus.reqFunc)) begin
                        w_next    = ECS_RELEASE;
                        w_fin_bad = 1'b1;
                    end else begin
                        w_next = ECS_DEMAND;
                    end
                end
            end
            ECS_DEMAND: begin
                w_limit = c_ACK_LAST;
                if (bus.ebusAck && bus.ebusXfer) begin
                    w_next    = ECS_RELEASE;
                    w_capture = !isWriteFunc(r_func);
                end else if (bus.ebusAck) begin
                    w_next = ECS_WAITXFER;
                end else if (w_hit) begin
                    w_next        = ECS_RELEASE;
                    w_fin_timeout = 1'b1;
                end
            end
            ECS_WAITXFER: begin
                w_limit = c_XFER_LAST;
                if (bus.ebusXfer) begin
                    w_next    = ECS_RELEASE;
                    w_capture = !isWriteFunc(r_func);
                end else if (w_hit) begin
                    w_next        = ECS_RELEASE;
                    w_fin_timeout = 1'b1;
                end
            end
            ECS_RELEASE: begin
                w_next = ECS_IDLE;
            end
            ECS_RESET: begin
                w_limit = c_RST_LAST;
                if (w_hit) begin
                    w_next = ECS_IDLE;
                end
            end
            default: begin
                w_next = ECS_IDLE;
            end
        endcase
    end

    // Hold the accepted request for the life of the transaction.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_func  <= ebusfCONO;
            r_cs    <= '0;
            r_wdata <= '0;
        end else begin
            r_func  <= w_func_nxt;
            r_cs    <= w_cs_nxt;
            r_wdata <= w_wdata_nxt;
        end
    end

    // Remember a reset request that arrives mid-transaction; IDLE services it.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_rst_pend <= 1'b0;
        end else if (r_state == ECS_IDLE) begin
            r_rst_pend <= 1'b0;
        end else if (r_state != ECS_RESET && bus.resetReq) begin
            r_rst_pend <= 1'b1;
        end
    end

    assign w_on_bus = (w_next == ECS_DEMAND) || (w_next == ECS_WAITXFER);
    assign w_drive  = w_on_bus && isWriteFunc(w_func_nxt);

    // Outputs are decoded from the next state and registered.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
            r_bad_func   <= 1'b0;
            r_rdata      <= '0;
            r_ebus_cs    <= '0;
            r_ebus_func  <= ebusfCONO;
            r_demand     <= 1'b0;
            r_ebus_reset <= 1'b0;
            r_drv        <= '0;
        end else begin
            r_busy       <= (w_next != ECS_IDLE);
            r_done       <= (w_next == ECS_RELEASE);
            r_timeout    <= w_fin_timeout;
            r_bad_func   <= w_fin_bad;
            // Only completion updates rdata; writes and aborts return zero.
            if (w_next == ECS_RELEASE) begin
                r_rdata <= w_capture ? bus.ebusData : '0;
            end
            r_ebus_cs     <= w_on_bus ? w_cs_nxt : '0;
            r_ebus_func   <= w_on_bus ? w_func_nxt : ebusfCONO;
            r_demand      <= w_on_bus;
            r_ebus_reset  <= (w_next == ECS_RESET);
            r_drv.driving <= w_drive;
            r_drv.data    <= w_drive ? w_wdata_nxt : '0;
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.timeout    = r_timeout;
    assign bus.badFunc    = r_bad_func;
    assign bus.rdata      = r_rdata;
    assign bus.ebusCs     = r_ebus_cs;
    assign bus.ebusFunc   = r_ebus_func;
    assign bus.ebusDemand = r_demand;
    assign bus.ebusReset  = r_ebus_reset;
    assign bus.ebusDrv    = r_drv;

endmodule : ebus_ctl
`default_nettype wire

// File: tb/tb_ebus_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ebus_ctl
// Brief    : Self-checking bench for ebus_ctl: directed vector table, hand
//            sequences for reset corners, and random transactions against a
//            cycle-count reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ebus_ctl;
    import ebus_ctl_pkg::*;

    localparam int ACK_T  = 32;
    localparam int XFER_T = 64;
    localparam int RST_C  = 8;

    logic clk = 1'b0;
    logic resetN;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [35:0] last_rdata;

    always #5 clk = ~clk;

    ebus_ctl_if bus ();

    ebus_ctl #(
        .ACK_TIMEOUT  (ACK_T),
        .XFER_TIMEOUT (XFER_T),
        .RESET_CYCLES (RST_C)
    ) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    typedef struct {
        logic [2:0]  func;
        logic [6:0]  cs;
        logic [35:0] wdata;
        int          ack_at;
        int          xfer_at;
        logic [35:0] bdata;
        int          exp_done;
        logic        exp_to;
        logic        exp_bad;
        logic [35:0] exp_rd;
    } vec_t;

    typedef struct {
        int          done_cyc;
        logic        to;
        logic        bad;
        logic [35:0] rd;
    } exp_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle-count view of a transaction. Cycle 1 is the cycle right after the
    // request edge; a device strobe "at k" is sampled on edge k after the request.
    function automatic exp_t predict(input logic [2:0] f, input int ack_at,
                                     input int xfer_at, input logic [35:0] bd);
        exp_t e;
        e.bad = (f == 3'd6) || (f == 3'd7);
        e.to  = 1'b0;
        e.rd  = '0;
        if (e.bad) begin
            e.done_cyc = 1;
            return e;
        end
        if (ack_at < 1 || ack_at > ACK_T) begin
            e.to = 1'b1;
            e.done_cyc = 1 + ACK_T;
        end else if (xfer_at == ack_at) begin
            e.done_cyc = ack_at + 1;
        end else if (xfer_at > ack_at && (xfer_at - ack_at) <= XFER_T) begin
            e.done_cyc = xfer_at + 1;
        end else begin
            e.to = 1'b1;
            e.done_cyc = ack_at + 1 + XFER_T;
        end
        if (!e.to && (f inside {3'd1, 3'd3, 3'd5})) e.rd = bd;
        return e;
    endfunction

    // Issue one request, play the device side with one-cycle ack/xfer strobes,
    // and check the handshake and completion against the expectations.
    task automatic run_txn(input string tag, input logic [2:0] f, input logic [6:0] cs,
                           input logic [35:0] wd, input int ack_at, input int xfer_at,
                           input logic [35:0] bd, input int exp_done, input logic exp_to,
                           input logic exp_bad, input logic [35:0] exp_rd);
        int   k;
        int   dem_cycles;
        int   hold_bad;
        logic wr;
        wr = f inside {3'd0, 3'd2, 3'd4};
        bus.reqFunc  = tEBUSfunction'(f);
        bus.reqCs    = cs;
        bus.reqData  = wd;
        bus.ebusData = bd;
        bus.ebusAck  = 1'b0;
        bus.ebusXfer = 1'b0;
        bus.req      = 1'b1;
        tick();
        bus.req = 1'b0;
        chk($sformatf("%s busy@1", tag), 64'(bus.busy), 64'd1);
        if (exp_done > 1) chk($sformatf("%s rdata hold", tag), 64'(bus.rdata), 64'(last_rdata));
        k = 0;
        dem_cycles = 0;
        hold_bad = 0;
        forever begin
            if (bus.ebusDemand) begin
                dem_cycles++;
                if (bus.ebusCs !== cs || 3'(bus.ebusFunc) !== f ||
                    bus.ebusDrv.driving !== wr || bus.ebusDrv.data !== (wr ? wd : 36'd0))
                    hold_bad++;
            end
            if (bus.done || k >= 300) break;
            k++;
            bus.ebusAck  = (k == ack_at);
            bus.ebusXfer = (k == xfer_at);
            tick();
        end
        bus.ebusAck  = 1'b0;
        bus.ebusXfer = 1'b0;
        chk($sformatf("%s done seen", tag), 64'(bus.done), 64'd1);
        chk($sformatf("%s done cycle", tag), 64'(k + 1), 64'(exp_done));
        chk($sformatf("%s demand cycles", tag), 64'(dem_cycles), 64'(exp_bad ? 0 : exp_done - 1));
        chk($sformatf("%s bus hold", tag), 64'(hold_bad), 64'd0);
        chk($sformatf("%s timeout", tag), 64'(bus.timeout), 64'(exp_to));
        chk($sformatf("%s badFunc", tag), 64'(bus.badFunc), 64'(exp_bad));
        chk($sformatf("%s rdata", tag), 64'(bus.rdata), 64'(exp_rd));
        chk($sformatf("%s bus idle at done", tag),
            64'({bus.ebusDemand, bus.ebusDrv.driving, bus.ebusCs, 3'(bus.ebusFunc)}), 64'd0);
        tick();
        chk($sformatf("%s done/busy after", tag), 64'({bus.done, bus.busy}), 64'd0);
        chk($sformatf("%s rdata after", tag), 64'(bus.rdata), 64'(exp_rd));
        last_rdata = exp_rd;
    endtask

    vec_t vecs[12];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   rst_cnt;
        int   rst_first;
        int   busy_bad;
        int   dem_seen;
        int   done_seen;
        int   bad_cnt;
        exp_t e;
        logic [63:0] r64;
        logic [2:0]  rf;
        int   ra;
        int   rx;

        vecs[0]  = '{3'd0, 7'o14, 36'o123456701234, 2, 3, 36'o555, 4, 1'b0, 1'b0, 36'o0};
        vecs[1]  = '{3'd3, 7'o10, 36'o0, 1, 1, 36'o777000111222, 2, 1'b0, 1'b0, 36'o777000111222};
        vecs[2]  = '{3'd1, 7'o20, 36'o0, 0, 0, 36'o1, 33, 1'b1, 1'b0, 36'o0};
        vecs[3]  = '{3'd7, 7'o30, 36'o5, 1, 1, 36'o7, 1, 1'b0, 1'b1, 36'o0};
        vecs[4]  = '{3'd6, 7'o31, 36'o6, 1, 1, 36'o7, 1, 1'b0, 1'b1, 36'o0};
        vecs[5]  = '{3'd3, 7'o40, 36'o0, 32, 32, 36'o42, 33, 1'b0, 1'b0, 36'o42};
        vecs[6]  = '{3'd3, 7'o41, 36'o0, 33, 33, 36'o43, 33, 1'b1, 1'b0, 36'o0};
        vecs[7]  = '{3'd2, 7'o50, 36'o707070707070, 1, 65, 36'o0, 66, 1'b0, 1'b0, 36'o0};
        vecs[8]  = '{3'd5, 7'o51, 36'o0, 2, 0, 36'o44, 67, 1'b1, 1'b0, 36'o0};
        vecs[9]  = '{3'd4, 7'o52, 36'o17, 3, 5, 36'o45, 6, 1'b0, 1'b0, 36'o0};
        vecs[10] = '{3'd3, 7'o53, 36'o0, 1, 66, 36'o46, 66, 1'b1, 1'b0, 36'o0};
        vecs[11] = '{3'd1, 7'o54, 36'o0, 4, 2, 36'o47, 69, 1'b1, 1'b0, 36'o0};

        bus.req      = 1'b0;
        bus.reqFunc  = ebusfCONO;
        bus.reqCs    = '0;
        bus.reqData  = '0;
        bus.resetReq = 1'b0;
        bus.ebusData = '0;
        bus.ebusAck  = 1'b0;
        bus.ebusXfer = 1'b0;
        resetN       = 1'b0;
        last_rdata   = '0;

        // Reset state
        tick();
        tick();
        chk("reset flags", 64'({bus.busy, bus.done, bus.timeout, bus.badFunc,
                                bus.ebusDemand, bus.ebusReset, bus.ebusDrv.driving}), 64'd0);
        chk("reset rdata", 64'(bus.rdata), 64'd0);
        chk("reset drv data", 64'(bus.ebusDrv.data), 64'd0);
        chk("reset cs/func", 64'({bus.ebusCs, 3'(bus.ebusFunc)}), 64'd0);
        resetN = 1'b1;
        tick();

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].func, vecs[i].cs, vecs[i].wdata,
                    vecs[i].ack_at, vecs[i].xfer_at, vecs[i].bdata, vecs[i].exp_done,
                    vecs[i].exp_to, vecs[i].exp_bad, vecs[i].exp_rd);
        end

        // Stale xfer holds off a request until it falls
        bus.reqFunc  = ebusfDATAI;
        bus.reqCs    = 7'o11;
        bus.ebusData = 36'o123;
        bus.ebusXfer = 1'b1;
        bus.req      = 1'b1;
        bad_cnt = 0;
        repeat (3) begin
            tick();
            if (bus.busy || bus.ebusDemand) bad_cnt++;
        end
        chk("stale xfer holdoff", 64'(bad_cnt), 64'd0);
        bus.ebusXfer = 1'b0;
        tick();
        bus.req = 1'b0;
        chk("accept after xfer falls", 64'({bus.busy, bus.ebusDemand}), 64'd3);
        bus.ebusAck  = 1'b1;
        bus.ebusXfer = 1'b1;
        tick();
        bus.ebusAck  = 1'b0;
        bus.ebusXfer = 1'b0;
        chk("holdoff txn done", 64'(bus.done), 64'd1);
        chk("holdoff txn rdata", 64'(bus.rdata), 64'o123);
        tick();
        last_rdata = 36'o123;

        // resetReq during a DATAO in WAITXFER: DATAO finishes, then the pulse
        bus.reqFunc = ebusfDATAO;
        bus.reqCs   = 7'o60;
        bus.reqData = 36'o111222333444;
        bus.req     = 1'b1;
        tick();
        bus.req = 1'b0;
        bus.ebusAck = 1'b1;
        tick();
        bus.ebusAck  = 1'b0;
        bus.resetReq = 1'b1;
        tick();
        bus.resetReq = 1'b0;
        chk("pending reset not early", 64'({bus.ebusReset, bus.ebusDemand}), 64'd1);
        bus.ebusXfer = 1'b1;
        tick();
        bus.ebusXfer = 1'b0;
        chk("datao done under pending reset", 64'({bus.done, bus.timeout, bus.ebusDrv.driving}), 64'd4);
        last_rdata = '0;
        rst_cnt = 0; rst_first = 0; busy_bad = 0; dem_seen = 0; done_seen = 0;
        bus.reqFunc = ebusfDATAI;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (bus.ebusReset) begin
                rst_cnt++;
                if (rst_first == 0) rst_first = i;
                if (!bus.busy) busy_bad++;
            end
            if (bus.ebusDemand) dem_seen++;
            if (bus.done) done_seen++;
            bus.req      = bus.ebusReset && (rst_cnt >= 1) && (rst_cnt <= 2);
            bus.resetReq = bus.ebusReset && (rst_cnt == 3);
        end
        bus.req = 1'b0;
        bus.resetReq = 1'b0;
        chk("reset pulse start", 64'(rst_first), 64'd2);
        chk("reset pulse width", 64'(rst_cnt), 64'(RST_C));
        chk("busy during reset", 64'(busy_bad), 64'd0);
        chk("req held off in reset", 64'(dem_seen), 64'd0);
        chk("no done for reset", 64'(done_seen), 64'd0);
        chk("idle after reset", 64'(bus.busy), 64'd0);

        // resetReq beats a simultaneous req in IDLE
        bus.reqFunc  = ebusfCONO;
        bus.req      = 1'b1;
        bus.resetReq = 1'b1;
        tick();
        bus.req      = 1'b0;
        bus.resetReq = 1'b0;
        chk("reset wins over req", 64'({bus.ebusReset, bus.ebusDemand}), 64'd2);
        rst_cnt = 1;
        dem_seen = 0;
        for (int i = 0; i < 20 && bus.busy; i++) begin
            tick();
            if (bus.ebusReset) rst_cnt++;
            if (bus.ebusDemand) dem_seen++;
        end
        chk("idle reset width", 64'({rst_cnt[7:0], dem_seen[7:0]}), 64'({8'(RST_C), 8'd0}));

        // Asynchronous resetN in DEMAND
        bus.reqFunc = ebusfCONI;
        bus.reqCs   = 7'o70;
        bus.req     = 1'b1;
        tick();
        bus.req = 1'b0;
        tick();
        chk("demand before resetN", 64'(bus.ebusDemand), 64'd1);
        #2;
        resetN = 1'b0;
        #1;
        chk("resetN drops bus", 64'({bus.ebusDemand, bus.busy, bus.done, bus.ebusCs}), 64'd0);
        tick();
        resetN = 1'b1;
        last_rdata = '0;
        tick();
        run_txn("post-reset DATAI", 3'd3, 7'o71, 36'o0, 2, 2, 36'o246, 3, 1'b0, 1'b0, 36'o246);

        // Random transactions against the model
        for (int i = 0; i < 40; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom_range(0, 36);
            case ($urandom_range(0, 2))
                0:       rx = ra;
                1:       rx = ra + $urandom_range(1, 70);
                default: rx = $urandom_range(0, 4);
            endcase
            r64 = {$urandom, $urandom};
            e = predict(rf, ra, rx, r64[35:0]);
            run_txn($sformatf("rnd%0d", i), rf, 7'($urandom_range(0, 127)), r64[63:28],
                    ra, rx, r64[35:0], e.done_cyc, e.to, e.bad, e.rd);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_ebus_ctl
`default_nettype wire
